// File: rtl/mic_tdoa_sequencer.sv
// mic_tdoa_sequencer: AHB-Lite slave that times the left/right microphone arrival difference.
module mic_tdoa_sequencer #(
   parameter int unsigned HOLDOFF_DEF = 20000000,
   parameter int unsigned TIMEOUT_DEF = 131071
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic [3:0]  HPROT,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP,
   input  logic        mic_left_n,
   input  logic        mic_right_n,
   output logic        irq
);

   localparam int unsigned AW     = 3;
   localparam int unsigned HO_W   = 25;
   localparam int unsigned TO_W   = 17;
   localparam int unsigned RES_W  = 18;
   localparam int unsigned EV_W   = 16;
   localparam int unsigned SYNC_W = 3;

   localparam logic [AW-1:0] A_CTRL    = AW'(0);
   localparam logic [AW-1:0] A_HOLDOFF = AW'(1);
   localparam logic [AW-1:0] A_TIMEOUT = AW'(2);
   localparam logic [AW-1:0] A_STATUS  = AW'(3);
   localparam logic [AW-1:0] A_RESULT  = AW'(4);
   localparam logic [AW-1:0] A_EVCNT   = AW'(5);

   localparam logic [HO_W-1:0] HO_RST = HO_W'(HOLDOFF_DEF);
   localparam logic [TO_W-1:0] TO_RST = TO_W'(TIMEOUT_DEF);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_WAIT    = 2'd2,
      S_HOLDOFF = 2'd3
   } state_t;

   // bus address-phase latch
   logic [AW-1:0]     addr_q, addr_d;
   logic              dwr_q, dwr_d;
   // mic synchronizers (bit 0 newest)
   logic [SYNC_W-1:0] sl_q, sl_d, sr_q, sr_d;
   // FSM and measurement datapath
   state_t            state_q, state_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              dir_q, dir_d;
   logic [TO_W-1:0]   tlim_q, tlim_d;
   logic [HO_W-1:0]   hcnt_q, hcnt_d;
   logic [HO_W-1:0]   hlim_q, hlim_d;
   // software-visible registers
   logic              en_q, en_d, cont_q, cont_d, irqen_q, irqen_d;
   logic [HO_W-1:0]   ho_q, ho_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              done_q, done_d, tmo_q, tmo_d, ovr_q, ovr_d;
   logic [RES_W-1:0]  res_q, res_d;
   logic [EV_W-1:0]   evcnt_q, evcnt_d;
   logic              irq_q, irq_d;

   // combinational helpers
   logic              wr, wr_ctrl, wr_ho, wr_to, wr_st;
   logic              en_wr, cont_wr;
   logic              ev_l, ev_r, opp;
   logic [RES_W-1:0]  elapsed;
   logic              tmo_hit, ho_fin;
   logic              res_set, tmo_set, en_hw_clr, enter_ho;
   logic [RES_W-1:0]  res_val;
   logic              unused_bits;

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign irq       = irq_q;

   assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:25]};

   // data-phase write strobes and the EN/CONT values seen by the FSM this cycle
   assign wr      = dwr_q & HREADY;
   assign wr_ctrl = wr && (addr_q == A_CTRL);
   assign wr_ho   = wr && (addr_q == A_HOLDOFF);
   assign wr_to   = wr && (addr_q == A_TIMEOUT);
   assign wr_st   = wr && (addr_q == A_STATUS);
   assign en_wr   = wr_ctrl ? HWDATA[0] : en_q;
   assign cont_wr = wr_ctrl ? HWDATA[1] : cont_q;

   // falling-edge detect on synchronized mic lines
   assign ev_l    = sl_q[2] & ~sl_q[1];
   assign ev_r    = sr_q[2] & ~sr_q[1];
   assign opp     = dir_q ? ev_r : ev_l;
   assign elapsed = {1'b0, cnt_q} + RES_W'(1);
   assign tmo_hit = elapsed >= {1'b0, tlim_q};
   assign ho_fin  = ({1'b0, hcnt_q} + (HO_W+1)'(1)) >= {1'b0, hlim_q};

   // address-phase capture, advanced only while the bus is ready
   always_comb begin
      addr_d = addr_q;
      dwr_d  = dwr_q;
      sl_d   = {sl_q[SYNC_W-2:0], mic_left_n};
      sr_d   = {sr_q[SYNC_W-2:0], mic_right_n};
      if (HREADY) begin
         dwr_d = HSEL & HTRANS[1] & HWRITE;
         if (HSEL && HTRANS[1]) begin
            addr_d = HADDR[4:2];
         end
      end
   end

   // FSM state register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state; clearing EN aborts from any state
   always_comb begin
      state_d = state_q;
      if (!en_wr) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:    state_d = S_ARMED;
            S_ARMED: begin
               if (ev_l && ev_r)      state_d = S_HOLDOFF;
               else if (ev_l || ev_r) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (opp || tmo_hit)    state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
               if (ho_fin)            state_d = cont_wr ? S_ARMED : S_IDLE;
            end
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs: interval/hold-off counters, result and flag strobes
   always_comb begin
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      tlim_d    = tlim_q;
      hcnt_d    = hcnt_q;
      hlim_d    = hlim_q;
      res_set   = 1'b0;
      res_val   = '0;
      tmo_set   = 1'b0;
      en_hw_clr = 1'b0;
      enter_ho  = 1'b0;
      if (en_wr) begin
         unique case (state_q)
            S_ARMED: begin
               if (ev_l && ev_r) begin
                  res_set  = 1'b1;
                  enter_ho = 1'b1;
               end else if (ev_l || ev_r) begin
                  dir_d  = ev_l;
                  cnt_d  = '0;
                  tlim_d = (to_q == '0) ? TO_W'(1) : to_q;
               end
            end
            S_WAIT: begin
               if (opp) begin
                  res_set  = 1'b1;
                  res_val  = dir_q ? elapsed : (~elapsed + RES_W'(1));
                  enter_ho = 1'b1;
               end else if (tmo_hit) begin
                  tmo_set  = 1'b1;
                  enter_ho = 1'b1;
               end else begin
                  cnt_d = elapsed[TO_W-1:0];
               end
            end
            S_HOLDOFF: begin
               if (ho_fin) begin
                  en_hw_clr = ~cont_wr;
               end else begin
                  hcnt_d = hcnt_q + HO_W'(1);
               end
            end
            default: ;
         endcase
      end
      if (enter_ho) begin
         hcnt_d = '0;
         hlim_d = ho_q;
      end
   end

   // register file updates; hardware flag sets win over W1C
   always_comb begin
      en_d    = en_wr & ~en_hw_clr;
      cont_d  = cont_wr;
      irqen_d = wr_ctrl ? HWDATA[2] : irqen_q;
      ho_d    = wr_ho ? HWDATA[HO_W-1:0] : ho_q;
      to_d    = wr_to ? HWDATA[TO_W-1:0] : to_q;
      done_d  = (done_q & ~(wr_st & HWDATA[4])) | res_set;
      tmo_d   = (tmo_q  & ~(wr_st & HWDATA[5])) | tmo_set;
      ovr_d   = (ovr_q  & ~(wr_st & HWDATA[6])) | (res_set & done_q);
      res_d   = res_set ? res_val : res_q;
      evcnt_d = res_set ? (evcnt_q + EV_W'(1)) : evcnt_q;
      irq_d   = done_d & irqen_d;
   end

   // datapath and register flops
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         addr_q  <= '0;
         dwr_q   <= 1'b0;
         sl_q    <= '1;
         sr_q    <= '1;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         tlim_q  <= TO_W'(1);
         hcnt_q  <= '0;
         hlim_q  <= '0;
         en_q    <= 1'b0;
         cont_q  <= 1'b0;
         irqen_q <= 1'b0;
         ho_q    <= HO_RST;
         to_q    <= TO_RST;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         ovr_q   <= 1'b0;
         res_q   <= '0;
         evcnt_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         dwr_q   <= dwr_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         tlim_q  <= tlim_d;
         hcnt_q  <= hcnt_d;
         hlim_q  <= hlim_d;
         en_q    <= en_d;
         cont_q  <= cont_d;
         irqen_q <= irqen_d;
         ho_q    <= ho_d;
         to_q    <= to_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
         ovr_q   <= ovr_d;
         res_q   <= res_d;
         evcnt_q <= evcnt_d;
         irq_q   <= irq_d;
      end
   end

   // read mux from the latched data-phase address
   always_comb begin
      HRDATA = '0;
      unique case (addr_q)
         A_CTRL:    HRDATA = {29'd0, irqen_q, cont_q, en_q};
         A_HOLDOFF: HRDATA = {7'd0, ho_q};
         A_TIMEOUT: HRDATA = {15'd0, to_q};
         A_STATUS:  HRDATA = {25'd0, ovr_q, tmo_q, done_q, 2'd0, 2'(state_q)};
         A_RESULT:  HRDATA = {{14{res_q[RES_W-1]}}, res_q};
         A_EVCNT:   HRDATA = {16'd0, evcnt_q};
         default:   HRDATA = '0;
      endcase
   end

endmodule

// File: tb/tb_mic_tdoa_sequencer.sv
// tb_mic_tdoa_sequencer: directed scenarios plus randomized trials against a timing-rule model.
module tb_mic_tdoa_sequencer;

   localparam logic [31:0] R_CTRL    = 32'h00;
   localparam logic [31:0] R_HOLDOFF = 32'h04;
   localparam logic [31:0] R_TIMEOUT = 32'h08;
   localparam logic [31:0] R_STATUS  = 32'h0C;
   localparam logic [31:0] R_RESULT  = 32'h10;
   localparam logic [31:0] R_EVCNT   = 32'h14;
   localparam logic [31:0] R_RSV0    = 32'h18;
   localparam logic [31:0] R_RSV1    = 32'h1C;

   logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic        mic_left_n, mic_right_n, irq;

   int          n_chk, n_err;
   int          ev_exp;
   logic [31:0] res_exp;
   logic [31:0] rd;

   mic_tdoa_sequencer dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
      .mic_left_n(mic_left_n), .mic_right_n(mic_right_n), .irq(irq)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      @(negedge HCLK);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      @(negedge HCLK);
      d = HRDATA;
      HSEL = 1'b0; HTRANS = 2'b00;
   endtask

   task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(a, v);
      check(tag, v, exp);
   endtask

   // step n cycles from a negedge; a mic is low for 3 cycles from its start cycle (<0 = silent)
   task automatic mic_seq(input int tl, input int tr, input int n);
      for (int k = 0; k < n; k++) begin
         mic_left_n  = !(tl >= 0 && k >= tl && k < tl + 3);
         mic_right_n = !(tr >= 0 && k >= tr && k < tr + 3);
         @(negedge HCLK);
      end
      mic_left_n  = 1'b1;
      mic_right_n = 1'b1;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   initial begin
      n_chk = 0; n_err = 0; ev_exp = 0; res_exp = '0;
      HSEL = 0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010; HPROT = 4'h3;
      HWRITE = 0; HWDATA = '0; HREADY = 1'b1;
      mic_left_n = 1'b1; mic_right_n = 1'b1;
      HRESET = 1'b1;
      repeat (3) @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);

      // reset values
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      check("rst_hresp", 32'(HRESP), 32'd0);
      chk_reg("rst_ctrl", R_CTRL, 32'd0);
      chk_reg("rst_holdoff", R_HOLDOFF, 32'd20000000);
      chk_reg("rst_timeout", R_TIMEOUT, 32'd131071);
      chk_reg("rst_status", R_STATUS, 32'd0);
      chk_reg("rst_result", R_RESULT, 32'd0);
      chk_reg("rst_evcnt", R_EVCNT, 32'd0);

      // left leads right by 50, single shot, hold-off of exactly 10 cycles
      bus_write(R_HOLDOFF, 32'd10);
      bus_write(R_TIMEOUT, 32'd1000);
      bus_write(R_CTRL, 32'h1);
      mic_seq(5, 55, 66);
      chk_reg("t1_status_in_holdoff", R_STATUS, 32'h13);
      chk_reg("t1_status_idle", R_STATUS, 32'h10);
      chk_reg("t1_result", R_RESULT, 32'd50);
      chk_reg("t1_evcnt", R_EVCNT, 32'd1);
      chk_reg("t1_ctrl_en_cleared", R_CTRL, 32'd0);

      // right leads by 200 in continuous mode with interrupt
      bus_write(R_STATUS, 32'h70);
      bus_write(R_CTRL, 32'h7);
      mic_seq(205, 5, 213);
      chk_reg("t2_result", R_RESULT, 32'hFFFF_FF38);
      check("t2_irq_set", 32'(irq), 32'd1);
      bus_write(R_STATUS, 32'h10);
      check("t2_irq_clr", 32'(irq), 32'd0);
      mic_seq(-1, -1, 10);
      chk_reg("t2_rearmed", R_STATUS, 32'h01);

      // simultaneous arrival, then a second result before DONE is cleared
      mic_seq(5, 5, 20);
      chk_reg("t3_result_zero", R_RESULT, 32'd0);
      chk_reg("t3_status", R_STATUS, 32'h11);
      mic_seq(5, 12, 27);
      chk_reg("t3_result_latest", R_RESULT, 32'd7);
      chk_reg("t3_status_ovr", R_STATUS, 32'h51);
      chk_reg("t3_evcnt", R_EVCNT, 32'd4);
      check("t3_irq", 32'(irq), 32'd1);

      // EN cleared mid-WAIT discards the measurement
      bus_write(R_STATUS, 32'h70);
      bus_write(R_CTRL, 32'h1);
      mic_seq(5, -1, 20);
      bus_write(R_CTRL, 32'h0);
      mic_seq(-1, 5, 20);
      chk_reg("t4_status_idle", R_STATUS, 32'h00);
      chk_reg("t4_result_kept", R_RESULT, 32'd7);
      chk_reg("t4_evcnt_kept", R_EVCNT, 32'd4);

      // pulses during hold-off are ignored
      bus_write(R_HOLDOFF, 32'd100);
      bus_write(R_CTRL, 32'h1);
      mic_seq(5, 5, 20);
      mic_seq(5, 10, 30);
      mic_seq(-1, -1, 80);
      chk_reg("t5_result", R_RESULT, 32'd0);
      chk_reg("t5_evcnt", R_EVCNT, 32'd5);
      chk_reg("t5_status", R_STATUS, 32'h10);
      chk_reg("t5_ctrl", R_CTRL, 32'd0);

      // asynchronous reset in the middle of hold-off
      bus_write(R_HOLDOFF, 32'd1000);
      bus_write(R_TIMEOUT, 32'd50);
      bus_write(R_STATUS, 32'h70);
      bus_write(R_CTRL, 32'h5);
      mic_seq(5, 5, 20);
      check("t6_irq_before", 32'(irq), 32'd1);
      chk_reg("t6_status_before", R_STATUS, 32'h13);
      HRESET = 1'b1;
      #1;
      check("t6_irq_in_reset", 32'(irq), 32'd0);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
      chk_reg("t6_ctrl", R_CTRL, 32'd0);
      chk_reg("t6_holdoff", R_HOLDOFF, 32'd20000000);
      chk_reg("t6_timeout", R_TIMEOUT, 32'd131071);
      chk_reg("t6_status", R_STATUS, 32'd0);
      chk_reg("t6_result", R_RESULT, 32'd0);
      chk_reg("t6_evcnt", R_EVCNT, 32'd0);
      bus_write(R_RSV0, 32'hFFFF_FFFF);
      chk_reg("t6_rsv18", R_RSV0, 32'd0);
      chk_reg("t6_rsv1c", R_RSV1, 32'd0);
      check("t6_irq", 32'(irq), 32'd0);
      ev_exp = 0;
      res_exp = '0;

      // randomized single-shot trials
      for (int t = 0; t < 30; t++) begin
         int tmo, tmo_eff, ho, mode, mag, tl, tr, n, irqen;
         logic valid;
         tmo     = (t == 5) ? 0 : int'($urandom_range(300, 1));
         tmo_eff = (tmo == 0) ? 1 : tmo;
         ho      = int'($urandom_range(20, 0));
         irqen   = int'($urandom_range(1, 0));
         mode    = (t < 4) ? t : int'($urandom_range(3, 0));
         tl = -1; tr = -1;
         case (mode)
            0: tl = 5;
            1: tr = 5;
            2: begin tl = 5; tr = 5; end
            default: begin
               case ($urandom_range(3, 0))
                  0: mag = tmo_eff;
                  1: mag = tmo_eff + 1;
                  default: mag = int'($urandom_range(32'(tmo_eff + 1), 1));
               endcase
               if (t == 3) mag = tmo_eff;
               if ($urandom_range(1, 0) == 1) begin
                  tl = 5; tr = 5 + mag;
               end else begin
                  tr = 5; tl = 5 + mag;
               end
            end
         endcase
         // a result needs both channels no further apart than the effective timeout
         valid = (tl >= 0) && (tr >= 0) && (iabs(tr - tl) <= tmo_eff);
         if (valid) begin
            ev_exp++;
            res_exp = 32'(tr - tl);
         end
         n = ((tl > tr) ? tl : tr) + tmo_eff + ho + 20;

         bus_write(R_STATUS, 32'h70);
         bus_write(R_TIMEOUT, 32'(tmo));
         bus_write(R_HOLDOFF, 32'(ho));
         bus_write(R_CTRL, 32'(1 | (irqen << 2)));
         mic_seq(tl, tr, n);
         chk_reg($sformatf("rnd%0d_status", t), R_STATUS,
                 {26'd0, !valid, valid, 4'd0});
         chk_reg($sformatf("rnd%0d_result", t), R_RESULT, res_exp);
         chk_reg($sformatf("rnd%0d_evcnt", t), R_EVCNT, 32'(ev_exp));
         chk_reg($sformatf("rnd%0d_ctrl", t), R_CTRL, 32'(irqen << 2));
         check($sformatf("rnd%0d_irq", t), 32'(irq), 32'(valid && irqen == 1));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mic_tdoa_sequencer.md
Name: mic_tdoa_sequencer

Overview:
AHB-Lite slave that sequences left/right microphone arrival-time measurement. It arms a capture window and detects the first-arriving channel. It times the interval to the opposite channel, bounded by a programmable timeout, then enforces a programmable hold-off before re-arming. Signed results, status flags and an interrupt go to the Cortex-M0 software. It sits on the AHB bus matrix beside the other audio peripherals.

Parameters:
HOLDOFF_DEF, 20000000, reset value of HOLDOFF register (cycles, 500 ms at 40 MHz)
TIMEOUT_DEF, 131071, reset value of TIMEOUT register (cycles)

Ports:
HCLK  input  1  system clock
HRESET  input  1  asynchronous reset, active-high
HSEL  input  1  slave select
HADDR  input  32  address; only [4:2] decoded
HTRANS  input  2  transfer type; HTRANS[1] = active
HSIZE  input  3  ignored, word access only
HPROT  input  4  ignored
HWRITE  input  1  write when 1
HWDATA  input  32  write data
HREADY  input  1  bus ready
HREADYOUT  output  1  tied 1
HRDATA  output  32  read data
HRESP  output  1  tied 0
mic_left_n  input  1  async active-low left mic pulse
mic_right_n  input  1  async active-low right mic pulse
irq  output  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Bus: address phase is latched when HSEL&HREADY&HTRANS[1]. The write is applied in the following data phase from HWDATA. HRDATA is decoded combinationally from the latched address. Zero wait states.
- Register map (byte offset):
  - 0x00 CTRL RW: b0 EN, b1 CONT, b2 IRQ_EN. Reset 0.
  - 0x04 HOLDOFF RW [24:0]. Reset HOLDOFF_DEF.
  - 0x08 TIMEOUT RW [16:0]. Reset TIMEOUT_DEF.
  - 0x0C STATUS: [1:0] state (RO), b4 DONE, b5 TMO, b6 OVR. Flags are W1C. Reset 0.
  - 0x10 RESULT RO: signed 18-bit delta, sign-extended to 32 bits. Reset 0.
  - 0x14 EVCNT RO: [15:0] valid-result count, wraps 0xFFFF->0. Reset 0.
  - 0x18/0x1C read 0; writes to them are ignored.
- Input conditioning: 2-FF synchronizer per mic, then falling-edge detect. This yields one-cycle pulses evL/evR, 3 cycles after the pin falls.
- FSM states (encoding shown in STATUS[1:0]):
  - IDLE=0: waits for EN=1, then goes to ARMED.
  - ARMED=1:
    - evL only: go to WAIT; dir=L; interval counter=0.
    - evR only: go to WAIT; dir=R; counter=0.
    - evL&evR in the same cycle: delta=0, result complete, go to HOLDOFF.
  - WAIT=2:
    - counter +1 per cycle.
    - Opposite-channel pulse at cycle t2 (first pulse at t1): delta=t2-t1. Sign is + if left first, - if right first. Result complete, go to HOLDOFF.
    - Same-channel re-pulses are ignored.
    - If t2-t1 reaches TIMEOUT with no opposite pulse: set TMO, no result, go to HOLDOFF.
    - An opposite pulse in the exact timeout cycle counts as a valid result; it has priority over timeout.
  - HOLDOFF=3:
    - Counts HOLDOFF cycles; all mic pulses are ignored.
    - At the end: ARMED if CONT=1, else IDLE with EN cleared by hardware.
    - HOLDOFF=0 exits after 1 cycle.
- Result complete, registered in the same clock edge:
  - RESULT is updated.
  - EVCNT increments.
  - If DONE is already set, OVR is set.
  - DONE is set.
- Simultaneous W1C of DONE and hardware set of DONE: the hardware set wins.
- EN write 0 in any state: go to IDLE next cycle, discard any in-flight measurement, keep the flags. EN write 1 while already active: no effect.
- HOLDOFF/TIMEOUT writes take effect at the next entry to HOLDOFF/WAIT. An in-progress count keeps its latched limit.
- TIMEOUT=0 is treated as 1.
- HRESET asserted at any time: all registers and the FSM return to reset values immediately; irq=0.

Test Plan:
- CTRL=0x1, HOLDOFF=10, TIMEOUT=1000; left falls at T, right falls at T+50 -> RESULT=50, DONE=1, EVCNT=1, state IDLE after 10 hold-off cycles, CTRL.EN=0.
- CTRL=0x7; right falls 200 cycles before left -> RESULT=0xFFFFFF38 (-200), irq=1; write STATUS=0x10 -> irq=0, state re-ARMED after hold-off.
- TIMEOUT=100; left only -> TMO=1 at t1+100, DONE=0, EVCNT unchanged. Repeat with right at exactly t1+100 -> RESULT=100, TMO=0.
- Both mics fall in the same cycle -> RESULT=0, DONE=1. In CONT mode, a second result before DONE is cleared -> OVR=1, RESULT=latest value.
- Clear EN mid-WAIT, then pulse the right mic -> state IDLE, RESULT/EVCNT unchanged. Mic pulses during HOLDOFF -> ignored.
- Assert HRESET mid-HOLDOFF -> HOLDOFF=20000000, TIMEOUT=131071, all other registers 0, irq=0. Reads of 0x18 -> 0.
